tone_generator: RTL and testbench
=================================

# tone_generator

Converts the 7-bit note code produced by the song sequencer into an audible square wave with coarse PWM volume control. The code is {octave[2:0], note[3:0]}. It sits directly downstream of the sequencer's note output and drives the board's buzzer/audio pin. Divider constants are fixed for the 16 MHz system clock.

## Interface
- CNT_W, 17: width of the half-period down-counter; must hold 122313.
- clk  in  1  system clock, 16 MHz.
- rst  in  1  asynchronous, active-high reset.
- note_in  in  7  {octave[6:4], note[3:0]} from the sequencer.
- vol  in  4  volume: 0 = mute, 1..7 = n/8 duty, 8..15 = full.
- audio_out  out  1  PWM-gated square wave to the pin.
- square_out  out  1  raw square wave, ungated.
- note_active  out  1  1 while a valid note is sounding.
- edge_pulse  out  1  one-cycle pulse on every square_out toggle.

## Operation
- Note decode:
  - note 0..11 = C..B.
  - note 12..15 = silence; 14 is the sequencer's explicit note-off.
  - octave 0..4 used directly.
  - octave 5..7 clamps to 4.
- Base half-periods at octave 0, in clk cycles, C..B: 122313, 115447, 108968, 102852, 97079, 91631, 86487, 81634, 77052, 72727, 68645, 64793.
- Octave scaling: period = base >> octave, using a logical right shift with truncation.
- Pipeline:
  - S1: note_q <= note_in.
  - S2: period_q <= LUT(note_q); valid_q <= (note < 12).
  - S3: generator.
- Generator states:
  - SILENT:
    - If valid_q: cnt <= period_q-1, square <= 1, active <= 1, edge_pulse <= 1, go to PLAY.
  - PLAY, !valid_q:
    - Go to SILENT immediately: square <= 0, cnt <= 0, active <= 0.
    - No edge_pulse.
  - PLAY, valid_q, cnt != 0:
    - cnt <= cnt-1.
  - PLAY, valid_q, cnt == 0:
    - square toggles and edge_pulse <= 1.
    - cnt <= period_q-1, taking the new period if the note changed.
    - A note change therefore completes the current half-period first, so there are no runt pulses.
- Each half-period is exactly period_q cycles, so frequency = 16e6 / (2·period_q).
- PWM:
  - pwm_cnt is a 3-bit free-running counter.
  - audio_out = square & ({1'b0,pwm_cnt} < vol), registered.
  - vol = 0 forces audio_out to 0.
  - vol >= 8 makes audio_out track square_out.
- Reset values:
  - Registers: note_q = 7'h0E; valid_q, square, cnt, pwm_cnt, active = 0.
  - Outputs: audio_out = 0, square_out = 0, note_active = 0, edge_pulse = 0.
- Reset mid-note: outputs drop to 0 asynchronously. After release the block is SILENT until a valid code passes S1/S2.

## Timing
- Edge numbering: note_in is stable before edge E0. note_q updates at E0 and period_q/valid_q at E1.
- Start from SILENT: after E2, square_out = 1, note_active = 1 and edge_pulse = 1 (for one cycle). audio_out follows one cycle later.
- Stop (code changes to silence): after E2, square_out = 0 and note_active = 0, regardless of phase.
- Note change while playing: the new period takes effect at the first cnt == 0 boundary at or after E2.
- Same code re-presented: no effect; phase continues uninterrupted.
- Codes held for less than one cycle: each is sampled only at clock edges, with no filtering.
- Simultaneous boundary and note change: the boundary toggle happens, and the reload uses the period_q present at that edge.

## Test plan
- Reset, vol=8, note_in=7'h09 (oct0 A):
  - square_out rises after E2.
  - It stays high exactly 72727 cycles, low 72727, and repeats.
  - edge_pulse appears once per toggle.
- note_in=7'h49 (oct4 A) → half-period 4545 cycles.
- note_in=7'h79 (oct7 A) → also 4545, confirming the clamp.
- Mid-half-period change 7'h09→7'h00:
  - The current half-period finishes at 72727 cycles.
  - The following half-periods are 122313 cycles each.
- Playing 7'h20, then note_in=7'h2E → square_out=0 and note_active=0 after E2.
- Silence check: codes 7'h0C, 7'h0D and 7'h0F each keep the block silent.
- PWM: note 7'h40 held, vol=3:
  - While square_out=1, audio_out is high 3 of every 8 cycles.
  - vol=0 → audio_out constantly 0.
  - vol=12 → audio_out equals square_out delayed one cycle.
- Reset mid-note: rst asserted between edges.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release with note_in=7'h09 held, playback restarts after 3 edges with a full 72727-cycle high phase.

Source files
------------

// File: rtl/tone_generator.sv
// Note-code to square-wave tone generator with 3-bit PWM volume gating.
// Three-stage pipeline: note capture, period lookup, half-period generator.
module tone_generator #(
    parameter int CNT_W = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] note_in,
    input  logic [3:0] vol,
    output logic       audio_out,
    output logic       square_out,
    output logic       note_active,
    output logic       edge_pulse
);

    typedef enum logic {
        SILENT = 1'b0,
        PLAY   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       note_q, note_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             square_q, square_d;
    logic             active_q, active_d;
    logic             pulse_q, pulse_d;
    logic [2:0]       pwm_cnt_q, pwm_cnt_d;
    logic             audio_q, audio_d;

    // Octave-0 half-periods in 16 MHz cycles, C..B.
    function automatic logic [CNT_W-1:0] base_period(input logic [3:0] n);
        logic [CNT_W-1:0] p;
        case (n)
            4'd0:    p = CNT_W'(122313);
            4'd1:    p = CNT_W'(115447);
            4'd2:    p = CNT_W'(108968);
            4'd3:    p = CNT_W'(102852);
            4'd4:    p = CNT_W'(97079);
            4'd5:    p = CNT_W'(91631);
            4'd6:    p = CNT_W'(86487);
            4'd7:    p = CNT_W'(81634);
            4'd8:    p = CNT_W'(77052);
            4'd9:    p = CNT_W'(72727);
            4'd10:   p = CNT_W'(68645);
            4'd11:   p = CNT_W'(64793);
            default: p = '0;
        endcase
        return p;
    endfunction

    // S1 / S2: capture and decode
    always_comb begin
        logic [2:0] oct;
        note_d   = note_in;
        oct      = (note_q[6:4] > 3'd4) ? 3'd4 : note_q[6:4];
        period_d = base_period(note_q[3:0]) >> oct;
        valid_d  = (note_q[3:0] < 4'd12);
    end

    // Generator state register and all datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SILENT;
            note_q    <= 7'h0E;
            period_q  <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            square_q  <= 1'b0;
            active_q  <= 1'b0;
            pulse_q   <= 1'b0;
            pwm_cnt_q <= 3'd0;
            audio_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            square_q  <= square_d;
            active_q  <= active_d;
            pulse_q   <= pulse_d;
            pwm_cnt_q <= pwm_cnt_d;
            audio_q   <= audio_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SILENT:  if (valid_q)  state_d = PLAY;
            PLAY:    if (!valid_q) state_d = SILENT;
            default: state_d = SILENT;
        endcase
    end

    // Generator outputs; a note change only reloads at a half-period boundary
    always_comb begin
        cnt_d    = cnt_q;
        square_d = square_q;
        active_d = active_q;
        pulse_d  = 1'b0;
        case (state_q)
            SILENT: begin
                if (valid_q) begin
                    cnt_d    = period_q - CNT_W'(1);
                    square_d = 1'b1;
                    active_d = 1'b1;
                    pulse_d  = 1'b1;
                end
            end
            PLAY: begin
                if (!valid_q) begin
                    cnt_d    = '0;
                    square_d = 1'b0;
                    active_d = 1'b0;
                end else if (cnt_q == '0) begin
                    cnt_d    = period_q - CNT_W'(1);
                    square_d = ~square_q;
                    pulse_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                square_d = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    // PWM gate: vol 0 never passes, vol >= 8 always passes
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 3'd1;
        audio_d   = square_q & ({1'b0, pwm_cnt_q} < vol);
    end

    assign audio_out   = audio_q;
    assign square_out  = square_q;
    assign note_active = active_q;
    assign edge_pulse  = pulse_q;

endmodule

// File: tb/tb_tone_generator.sv
// Randomized and directed bench for tone_generator against a cycle-level
// behavioural model built from note periods and a two-deep code history.
module tb_tone_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] note_in = 7'h0E;
    logic [3:0] vol = 4'd0;
    logic       audio_out, square_out, note_active, edge_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    tone_generator #(.CNT_W(17)) dut (
        .clk(clk), .rst(rst), .note_in(note_in), .vol(vol),
        .audio_out(audio_out), .square_out(square_out),
        .note_active(note_active), .edge_pulse(edge_pulse)
    );

    always #5 clk = ~clk;

    int base_tab[12] = '{122313, 115447, 108968, 102852, 97079, 91631,
                         86487, 81634, 77052, 72727, 68645, 64793};

    // model: codes seen by S1 and S2, plus sounding state
    logic [6:0] m_code1, m_code2;
    bit m_play, m_sq, m_pulse, m_audio;
    int m_left, m_ec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period_of(input logic [6:0] c);
        int o;
        o = int'(c[6:4]);
        if (o > 4) o = 4;
        return base_tab[c[3:0]] >> o;
    endfunction

    task automatic model_reset();
        m_code1 = 7'h0E;
        m_code2 = 7'h0E;
        m_play  = 0;
        m_sq    = 0;
        m_pulse = 0;
        m_audio = 0;
        m_left  = 0;
        m_ec    = 0;
    endtask

    task automatic step();
        logic [6:0] c;
        bit v;
        @(posedge clk);
        c = m_code2;
        v = (c[3:0] < 4'd12);
        m_audio = m_sq && ((m_ec % 8) < int'(vol));
        m_ec++;
        m_pulse = 0;
        if (!m_play) begin
            if (v) begin
                m_play = 1; m_sq = 1; m_pulse = 1; m_left = period_of(c);
            end
        end else if (!v) begin
            m_play = 0; m_sq = 0;
        end else if (m_left == 1) begin
            m_sq = !m_sq; m_pulse = 1; m_left = period_of(c);
        end else begin
            m_left--;
        end
        m_code2 = m_code1;
        m_code1 = note_in;
        #1;
        chk("outs", {28'd0, audio_out, square_out, note_active, edge_pulse},
            {28'd0, m_audio, m_sq, m_play, m_pulse});
    endtask

    task automatic until_toggle(input int limit, output int n);
        logic s0;
        s0 = square_out;
        n = 0;
        do begin
            step();
            n++;
        end while (square_out == s0 && n < limit);
    endtask

    task automatic count_audio(input int cycles, output int hi);
        hi = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (audio_out) hi++;
        end
    endtask

    initial begin
        int n, hi;
        logic [6:0] rc;
        model_reset();
        #1;
        chk("reset_outs", {28'd0, audio_out, square_out, note_active, edge_pulse}, 0);
        #11 rst = 1'b0;
        repeat (4) step();

        // start latency and A4 half-periods
        vol = 4'd8;
        note_in = 7'h49;
        until_toggle(20, n);
        chk("start_lat", n, 3);
        until_toggle(6000, n);
        chk("hp_a4_hi", n, 4545);
        until_toggle(6000, n);
        chk("hp_a4_lo", n, 4545);

        // octave clamp
        note_in = 7'h79;
        until_toggle(6000, n);
        chk("hp_clamp", n, 4545);

        // mid-half-period change finishes the current half first
        repeat (1000) step();
        note_in = 7'h40;
        until_toggle(6000, n);
        chk("mid_rest", n, 3545);
        until_toggle(9000, n);
        chk("hp_c4", n, 7644);

        // PWM duty while square is high
        vol = 4'd3;
        n = 0;
        do begin step(); n++; end while (!(square_out && edge_pulse) && n < 20000);
        chk("pwm_wait", int'(n < 20000), 1);
        repeat (2) step();
        count_audio(64, hi);
        chk("pwm_vol3", hi, 24);
        vol = 4'd0;
        count_audio(64, hi);
        chk("pwm_vol0", hi, 0);
        vol = 4'd12;
        repeat (64) step();

        // stop regardless of phase
        vol = 4'd8;
        note_in = 7'h2E;
        repeat (3) step();
        note_in = 7'h20;
        until_toggle(20, n);
        chk("start_c2", n, 3);
        repeat (10) step();
        note_in = 7'h2E;
        repeat (2) step();
        chk("stop_e1_active", note_active, 1);
        step();
        chk("stop_active", note_active, 0);
        chk("stop_square", square_out, 0);

        // silence codes
        foreach (base_tab[i]) if (i < 3) begin
            rc = (i == 0) ? 7'h0C : (i == 1) ? 7'h0D : 7'h0F;
            note_in = rc;
            repeat (20) step();
            chk("silent_active", note_active, 0);
        end

        // random codes, holds and volumes
        for (int s = 0; s < 150; s++) begin
            note_in = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) vol = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) n = $urandom_range(1, 400);
            else n = $urandom_range(1, 8);
            repeat (n) step();
        end

        // async reset mid-note, then clean restart
        vol = 4'd8;
        note_in = 7'h2E;
        repeat (3) step();
        note_in = 7'h49;
        repeat (12) step();
        chk("pre_rst_play", {30'd0, square_out, audio_out}, 3);
        #3 rst = 1'b1;
        #1;
        chk("rst_async", {28'd0, audio_out, square_out, note_active, edge_pulse}, 0);
        model_reset();
        #1 rst = 1'b0;
        until_toggle(20, n);
        chk("rst_restart", n, 3);
        until_toggle(6000, n);
        chk("rst_hp", n, 4545);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
